// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types for the UART TX path: the packet arbiter FSM state encoding
//   and the width/type of its inter-packet gap counter.
package uart_pkg;

  // Gap counter width; caps the inter-packet gap at 255 idle cycles.
  localparam int unsigned GAP_CNT_W = 8;
  typedef logic [GAP_CNT_W-1:0] gap_cnt_t;

  // Largest requester count the arbiter is built for.
  localparam int unsigned MAX_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no owner, waiting for any requester
    ST_XFER = 2'd1,  // owner granted, bytes flow until tlast is accepted
    ST_GAP  = 2'd2   // enforced idle cycles after a packet
  } arb_state_e;

endpackage

// File: rtl/rr_select.sv
// rr_select
//   Combinational round-robin picker. Searches the request vector starting
//   one position after ptr_i, wrapping around, and returns the first active
//   requester as a one-hot vector (all-zero when nothing is requesting).
// Ports:
//   req_i  - request vector, one bit per requester
//   ptr_i  - index of the previous winner
//   gnt_o  - one-hot winner
module rr_select
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  int unsigned cand;
  logic        found;

  // Offsets 1..NUM_REQ from the pointer; the last offset revisits the
  // previous winner so a lone requester can win again.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned ofs = 1; ofs <= NUM_REQ; ofs++) begin
      cand = (32'(ptr_i) + ofs) % NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req_i[j] && (j == cand)) begin
          gnt_o[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tx_packet_arbiter.sv
// tx_packet_arbiter
//   Packet-level round-robin arbiter feeding a single UART TX byte stream.
//   A requester is granted for a whole packet (until its tlast byte is
//   accepted); optionally a fixed number of idle cycles follows each packet.
//   No data is stored: the granted requester's stream is muxed straight
//   through to the output and the sink's ready is routed straight back.
// Ports:
//   clk_i, rst_i      - clock (rising edge), asynchronous active-low reset
//   req_tdata_i       - packed requester bytes, requester k at [k*DW +: DW]
//   req_tvalid_i      - per-requester byte valid
//   req_tlast_i       - per-requester last byte of packet
//   req_tready_o      - per-requester byte accepted (owner only)
//   m_tdata_o/_tvalid_o/_tlast_o - byte stream to UART TX
//   m_tready_i        - UART TX ready
//   grant_o           - one-hot current owner, zero when none
//   busy_o            - high while transferring or in the post-packet gap
module tx_packet_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata_i,
  input  logic [NUM_REQ-1:0]            req_tvalid_i,
  input  logic [NUM_REQ-1:0]            req_tlast_i,
  output logic [NUM_REQ-1:0]            req_tready_o,
  output logic [DATA_WIDTH-1:0]         m_tdata_o,
  output logic                          m_tvalid_o,
  output logic                          m_tlast_o,
  input  logic                          m_tready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  localparam int unsigned      PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);
  localparam gap_cnt_t         GAP_LOAD = gap_cnt_t'(GAP_CYCLES);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] grant_d;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  gap_cnt_t           gap_cnt_q;
  logic               pkt_end;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_select (
    .req_i (req_tvalid_i),
    .ptr_i (ptr_q),
    .gnt_o (grant_d)
  );

  // One-hot winner to index, for the round-robin pointer.
  always_comb begin
    ptr_d = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant_d[j]) ptr_d = PTR_W'(j);
    end
  end

  // grant_q is only non-zero in XFER, so the mux alone gives zero outputs
  // in IDLE, GAP and reset; tvalid never sees m_tready_i.
  always_comb begin
    m_tdata_o  = '0;
    m_tvalid_o = 1'b0;
    m_tlast_o  = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant_q[j]) begin
        m_tdata_o  = m_tdata_o | req_tdata_i[j*DATA_WIDTH +: DATA_WIDTH];
        m_tvalid_o = m_tvalid_o | req_tvalid_i[j];
        m_tlast_o  = m_tlast_o | req_tlast_i[j];
      end
    end
  end

  assign req_tready_o = grant_q & {NUM_REQ{m_tready_i}};
  assign grant_o      = grant_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign pkt_end      = (state_q == ST_XFER) && m_tvalid_o && m_tready_i && m_tlast_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= PTR_RST;
      gap_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|req_tvalid_i) begin
            state_q <= ST_XFER;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
          end
        end
        ST_XFER: begin
          if (pkt_end) begin
            grant_q <= '0;
            if (GAP_CYCLES > 0) begin
              state_q   <= ST_GAP;
              gap_cnt_q <= GAP_LOAD;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          // Loaded with GAP_CYCLES; leaving at 1 yields exactly that many
          // GAP cycles and parks the counter at zero.
          gap_cnt_q <= gap_cnt_q - gap_cnt_t'(1);
          if (gap_cnt_q == gap_cnt_t'(1)) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// tb_tx_packet_arbiter
//   Two arbiter instances (no gap, 3-cycle gap) share one set of requester
//   inputs; sel picks which one the sources and the scoreboard talk to.
//   Requester sources play queued beats; expected beats (data, last, owner)
//   are queued in predicted arbitration order and checked as they leave.
module tb_tx_packet_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned DW = 8;

  typedef struct {
    logic [7:0]  data;
    logic        last;
    int unsigned idle;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] grant;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR*DW-1:0] tdata;
  logic [NR-1:0]   tvalid;
  logic [NR-1:0]   tlast;
  logic            mready;
  logic            sel;

  logic [NR-1:0] a_tready, a_grant, b_tready, b_grant;
  logic [DW-1:0] a_mdata, b_mdata;
  logic          a_mvalid, a_mlast, a_busy, b_mvalid, b_mlast, b_busy;

  logic [NR-1:0] s_tready, s_grant;
  logic [DW-1:0] s_mdata;
  logic          s_mvalid, s_mlast, s_busy;

  beat_t       src0_q[$];
  beat_t       src1_q[$];
  exp_t        exp_q[$];
  int unsigned acc_cyc_q[$];
  int unsigned cyc = 0;
  int unsigned n_beats = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned rise0 = 0;
  int unsigned rise1 = 0;

  tx_packet_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .GAP_CYCLES (0)
  ) u_dut_a (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .req_tdata_i  (tdata),
    .req_tvalid_i (tvalid),
    .req_tlast_i  (tlast),
    .req_tready_o (a_tready),
    .m_tdata_o    (a_mdata),
    .m_tvalid_o   (a_mvalid),
    .m_tlast_o    (a_mlast),
    .m_tready_i   (mready),
    .grant_o      (a_grant),
    .busy_o       (a_busy)
  );

  tx_packet_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .GAP_CYCLES (3)
  ) u_dut_b (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .req_tdata_i  (tdata),
    .req_tvalid_i (tvalid),
    .req_tlast_i  (tlast),
    .req_tready_o (b_tready),
    .m_tdata_o    (b_mdata),
    .m_tvalid_o   (b_mvalid),
    .m_tlast_o    (b_mlast),
    .m_tready_i   (mready),
    .grant_o      (b_grant),
    .busy_o       (b_busy)
  );

  always_comb begin
    if (sel) begin
      s_tready = b_tready; s_grant = b_grant; s_mdata = b_mdata;
      s_mvalid = b_mvalid; s_mlast = b_mlast; s_busy  = b_busy;
    end else begin
      s_tready = a_tready; s_grant = a_grant; s_mdata = a_mdata;
      s_mvalid = a_mvalid; s_mlast = a_mlast; s_busy  = a_busy;
    end
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_src(input int unsigned k, input logic [7:0] d, input logic l,
                          input int unsigned idle);
    beat_t b;
    b.data = d; b.last = l; b.idle = idle;
    if (k == 0) src0_q.push_back(b);
    else        src1_q.push_back(b);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l, input logic [1:0] g);
    exp_t e;
    e.data = d; e.last = l; e.grant = g;
    exp_q.push_back(e);
  endtask

  // n-byte packet d0, d0+1, ... from requester k, expected under grant 1<<k.
  task automatic push_pkt(input int unsigned k, input logic [7:0] d0, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      push_src(k, d0 + 8'(i), (i == n - 1), 0);
      push_exp(d0 + 8'(i), (i == n - 1), (k == 0) ? 2'b01 : 2'b10);
    end
  endtask

  task automatic wait_beats(input int unsigned target, input string tag);
    int unsigned budget;
    budget = 200;
    while (n_beats < target && budget > 0) begin
      @(negedge clk); #2;
      budget--;
    end
    if (n_beats < target) check_eq({"timeout_", tag}, n_beats, target);
  endtask

  function automatic int unsigned acc_gap(input int unsigned i);
    if (acc_cyc_q.size() > i + 1) return acc_cyc_q[i+1] - acc_cyc_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int unsigned acc_at(input int unsigned i);
    if (acc_cyc_q.size() > i) return acc_cyc_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check_idle(input string pfx);
    check_eq({pfx, "_mvalid"}, s_mvalid, 0);
    check_eq({pfx, "_mlast"},  s_mlast,  0);
    check_eq({pfx, "_tready"}, s_tready, 0);
    check_eq({pfx, "_busy"},   s_busy,   0);
    check_eq({pfx, "_mdata"},  s_mdata,  0);
    check_eq({pfx, "_grant"},  s_grant,  0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src0_q.delete(); src1_q.delete(); exp_q.delete();
    mready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requester sources: beat accepted on a cycle is retired after the edge.
  initial begin : src_drv
    logic [1:0] acc;
    logic [1:0] prev;
    beat_t      b;
    tvalid = '0; tlast = '0; tdata = '0;
    forever begin
      @(negedge clk);
      acc = tvalid & s_tready;
      @(posedge clk); #1;
      prev = tvalid;
      if (acc[0] && src0_q.size() > 0) void'(src0_q.pop_front());
      if (acc[1] && src1_q.size() > 0) void'(src1_q.pop_front());
      if (src0_q.size() == 0) begin
        tvalid[0] = 1'b0; tlast[0] = 1'b0; tdata[7:0] = '0;
      end else if (src0_q[0].idle != 0) begin
        b = src0_q.pop_front(); b.idle = b.idle - 1; src0_q.push_front(b);
        tvalid[0] = 1'b0; tlast[0] = 1'b0; tdata[7:0] = '0;
      end else begin
        tvalid[0] = 1'b1; tlast[0] = src0_q[0].last; tdata[7:0] = src0_q[0].data;
      end
      if (src1_q.size() == 0) begin
        tvalid[1] = 1'b0; tlast[1] = 1'b0; tdata[15:8] = '0;
      end else if (src1_q[0].idle != 0) begin
        b = src1_q.pop_front(); b.idle = b.idle - 1; src1_q.push_front(b);
        tvalid[1] = 1'b0; tlast[1] = 1'b0; tdata[15:8] = '0;
      end else begin
        tvalid[1] = 1'b1; tlast[1] = src1_q[0].last; tdata[15:8] = src1_q[0].data;
      end
      if (tvalid[0] && !prev[0]) rise0 = cyc;
      if (tvalid[1] && !prev[1]) rise1 = cyc;
    end
  end

  // Output monitor / scoreboard.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (s_mvalid && mready) begin
        n_beats++;
        acc_cyc_q.push_back(cyc);
        check_eq("sb_beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("sb_data",  s_mdata, e.data);
          check_eq("sb_last",  s_mlast, e.last);
          check_eq("sb_grant", s_grant, e.grant);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned base;
    rst_n = 1'b0; mready = 1'b1; sel = 1'b0;

    // Reset state, both instances.
    repeat (3) @(negedge clk); #2;
    check_idle("rst_a");
    sel = 1'b1; #1;
    check_idle("rst_b");
    sel = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #2;
    check_idle("post_rst_a");

    // T1: three-byte packet from requester 0, one-cycle latency, back-to-back bytes.
    acc_cyc_q.delete(); base = n_beats;
    @(posedge clk); #2;
    push_src(0, 8'h11, 1'b0, 0); push_exp(8'h11, 1'b0, 2'b01);
    push_src(0, 8'h22, 1'b0, 0); push_exp(8'h22, 1'b0, 2'b01);
    push_src(0, 8'h33, 1'b1, 0); push_exp(8'h33, 1'b1, 2'b01);
    wait_beats(base + 3, "t1");
    check_eq("t1_latency", acc_at(0) - rise0, 1);
    check_eq("t1_consec0", acc_gap(0), 1);
    check_eq("t1_consec1", acc_gap(1), 1);
    @(negedge clk); #2;
    check_eq("t1_grant_clear", s_grant, 0);
    check_eq("t1_busy_clear",  s_busy,  0);

    // T2: both requesters continuously busy with 2-byte packets; alternating owners.
    do_reset();
    acc_cyc_q.delete(); base = n_beats;
    @(posedge clk); #2;
    push_pkt(0, 8'hA0, 2); push_pkt(1, 8'hB0, 2);
    push_pkt(0, 8'hA4, 2); push_pkt(1, 8'hB4, 2);
    wait_beats(base + 8, "t2");
    check_eq("t2_intra_pkt", acc_gap(0), 1);
    check_eq("t2_idle_gap0", acc_gap(1), 2);
    check_eq("t2_idle_gap1", acc_gap(3), 2);
    check_eq("t2_idle_gap2", acc_gap(5), 2);

    // T3: owner 1 stalls tvalid for 4 cycles while requester 0 waits.
    do_reset();
    acc_cyc_q.delete(); base = n_beats;
    @(posedge clk); #2;
    push_src(1, 8'hC1, 1'b0, 0); push_exp(8'hC1, 1'b0, 2'b10);
    push_src(1, 8'hC2, 1'b0, 4); push_exp(8'hC2, 1'b0, 2'b10);
    push_src(1, 8'hC3, 1'b1, 0); push_exp(8'hC3, 1'b1, 2'b10);
    @(posedge clk); #2;
    push_pkt(0, 8'hD1, 2);
    wait_beats(base + 1, "t3_first");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      check_eq("t3_hold_grant", s_grant, 2'b10);
      check_eq("t3_gap_mvalid", s_mvalid, 0);
    end
    wait_beats(base + 5, "t3");

    // T4: sink stalls 5 cycles on the last byte.
    acc_cyc_q.delete(); base = n_beats;
    @(posedge clk); #2;
    push_pkt(0, 8'hE1, 2);
    wait_beats(base + 1, "t4_first");
    @(posedge clk); #1; mready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      check_eq("t4_stall_data",   s_mdata,  8'hE2);
      check_eq("t4_stall_last",   s_mlast,  1);
      check_eq("t4_stall_valid",  s_mvalid, 1);
      check_eq("t4_stall_tready", s_tready, 0);
    end
    @(posedge clk); #1; mready = 1'b1;
    wait_beats(base + 2, "t4");

    // T5: reset during byte 2 of a 4-byte packet; requester 0 wins afterwards.
    acc_cyc_q.delete(); base = n_beats;
    @(posedge clk); #2;
    push_pkt(0, 8'hF1, 4);
    wait_beats(base + 1, "t5_first");
    @(posedge clk); #1; mready = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    check_idle("t5_in_rst");
    src0_q.delete(); src1_q.delete(); exp_q.delete();
    mready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #2;
    check_idle("t5_post_rst");
    base = n_beats;
    @(posedge clk); #2;
    push_pkt(0, 8'h61, 2); push_pkt(1, 8'h71, 2);
    wait_beats(base + 4, "t5");

    // T6: 3-cycle gap instance, two back-to-back packets.
    sel = 1'b1;
    do_reset();
    #2;
    check_idle("t6_rst_b");
    acc_cyc_q.delete(); base = n_beats;
    @(posedge clk); #2;
    push_pkt(0, 8'h81, 2); push_pkt(1, 8'h91, 2);
    wait_beats(base + 2, "t6_first");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      check_eq("t6_gap_busy",   s_busy,   1);
      check_eq("t6_gap_grant",  s_grant,  0);
      check_eq("t6_gap_mvalid", s_mvalid, 0);
    end
    @(negedge clk); #2;
    check_eq("t6_idle_busy",  s_busy,  0);
    check_eq("t6_idle_grant", s_grant, 0);
    @(negedge clk); #2;
    check_eq("t6_next_grant", s_grant, 2'b10);
    wait_beats(base + 4, "t6");
    check_eq("t6_last_to_first", acc_gap(1), 5);

    // T7: single-byte packets on the no-gap instance.
    sel = 1'b0;
    do_reset();
    acc_cyc_q.delete(); base = n_beats;
    @(posedge clk); #2;
    push_pkt(1, 8'h5A, 1);
    wait_beats(base + 1, "t7_single");
    @(negedge clk); #2;
    check_eq("t7_grant_clear", s_grant, 0);
    check_eq("t7_busy_clear",  s_busy,  0);
    @(posedge clk); #2;
    push_pkt(0, 8'h3C, 1); push_pkt(1, 8'h4D, 1);
    wait_beats(base + 3, "t7_pair");
    check_eq("t7_pair_spacing", acc_gap(1), 2);

    repeat (2) @(negedge clk);
    check_eq("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_packet_arbiter.md
TX_PACKET_ARBITER -- requirements
Module: tx_packet_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, meaning number of response sources (legal 2..4).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning byte width of every stream.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 0, meaning idle cycles inserted after each packet (legal 0..255).
REQ-004 Port clk_i  in  1  clock; all logic SHALL be rising-edge.
REQ-005 Port rst_i  in  1  reset, asynchronous, active-low.
REQ-006 Port req_tdata_i  in  NUM_REQ*DATA_WIDTH  requester bytes; requester k occupies slice [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 Port req_tvalid_i  in  NUM_REQ  per-requester byte valid.
REQ-008 Port req_tlast_i  in  NUM_REQ  per-requester last byte of packet.
REQ-009 Port req_tready_o  out  NUM_REQ  per-requester byte accepted.
REQ-010 Port m_tdata_o  out  DATA_WIDTH  byte to UART TX.
REQ-011 Port m_tvalid_o  out  1  byte valid to UART TX.
REQ-012 Port m_tlast_o  out  1  last byte of current packet.
REQ-013 Port m_tready_i  in  1  UART TX ready.
REQ-014 Port grant_o  out  NUM_REQ  one-hot current owner, all-zero when no owner.
REQ-015 Port busy_o  out  1  high in XFER or GAP state.

Function
REQ-016 The FSM SHALL have states IDLE, XFER, GAP.
REQ-017 IDLE: when any req_tvalid_i bit is high, the block SHALL select a winner round-robin and enter XFER with grant_o set on the next edge.
REQ-018 Round-robin search SHALL start at (last_winner+1) mod NUM_REQ and wrap; the pointer SHALL update only when a grant is issued.
REQ-019 In IDLE, m_tvalid_o, req_tready_o and grant_o SHALL be zero; no byte SHALL be accepted.
REQ-020 XFER: m_tdata_o/m_tvalid_o/m_tlast_o SHALL combinationally equal the granted requester's tdata/tvalid/tlast; only the granted req_tready_o bit SHALL equal m_tready_i, all others zero.
REQ-021 Grant SHALL be held for the whole packet, regardless of tvalid gaps from the owner or new requests from others.
REQ-022 A beat with m_tvalid_o & m_tready_i & m_tlast_o SHALL end the packet: next state GAP if GAP_CYCLES>0, else IDLE; grant_o clears on that edge.
REQ-023 GAP: an 8-bit counter loaded with GAP_CYCLES SHALL decrement each cycle; at 1 the FSM SHALL return to IDLE, giving exactly GAP_CYCLES cycles with grant_o=0 and m_tvalid_o=0.
REQ-024 Latency: requester valid in IDLE at cycle N SHALL allow the first byte to transfer at cycle N+1 at the earliest.
REQ-025 With GAP_CYCLES=0, back-to-back packets SHALL have exactly one IDLE cycle between the last byte of one and the first of the next.
REQ-026 A single-byte packet (tvalid and tlast together) SHALL be handled as a complete packet.
REQ-027 m_tvalid_o SHALL never depend combinationally on m_tready_i.

Reset
REQ-028 On rst_i low the FSM SHALL go to IDLE, grant_o to zero, gap counter to zero, round-robin pointer to NUM_REQ-1 (requester 0 first).
REQ-029 During and immediately after reset, m_tvalid_o, m_tlast_o, req_tready_o, busy_o SHALL be zero and m_tdata_o zero.
REQ-030 Reset asserted mid-packet SHALL abandon the packet; no partial-packet state SHALL survive.

Structure
REQ-031 The state enum and GAP counter width SHALL live in the shared uart_pkg package.
REQ-032 The round-robin picker SHALL be a combinational sub-module rr_select (inputs request vector and pointer, output one-hot winner).
REQ-033 No storage of data bytes SHALL exist in the block; it is a pure sequencer.

Verification
REQ-034 Req0 sends 3 bytes 0x11,0x22,0x33(last), m_tready_i=1 -> m_tdata 0x11,0x22,0x33 on three consecutive cycles starting one cycle after tvalid, grant_o=01.
REQ-035 Req0 and Req1 both valid continuously with 2-byte packets -> grants alternate 01,10,01,10; no byte interleaving.
REQ-036 Req1 inserts a 4-cycle tvalid gap mid-packet while Req0 requests -> grant_o stays 10 until Req1 tlast accepted.
REQ-037 GAP_CYCLES=3, two back-to-back packets -> exactly 3 cycles with busy_o=1, grant_o=0 after the last byte, then 1 IDLE cycle, then new grant.
REQ-038 m_tready_i held low 5 cycles during a byte -> byte and tlast held stable, owner's req_tready_o low, no loss.
REQ-039 rst_i pulsed low during byte 2 of a 4-byte packet -> outputs zero immediately; after release, Req0 wins first.
